// File: rtl/dm_access_seq.sv
// MEM-stage access sequencer for a synchronous byte-enabled data BRAM with fixed read latency.
// Holds the pipeline while a load/store is in flight and flags misaligned accesses precisely.
module dm_access_seq #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned READ_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [2:0]            req_dm_ctrl,
  input  logic [3:0]            req_wea,
  input  logic [31:0]           req_wdata,
  output logic                  stall,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  misalign_exc,
  output logic [31:0]           misalign_addr,
  output logic                  bram_en,
  output logic [3:0]            bram_wea,
  output logic [DEPTH_LOG2-1:0] bram_addr,
  output logic [31:0]           bram_din,
  input  logic [31:0]           bram_dout
);

  typedef enum logic [2:0] {StIdle, StAcc, StWait, StResp, StExc} state_e;

  localparam logic [1:0] LatInit = 2'(READ_LAT);

  state_e     state_q;
  logic       we_q;
  logic [1:0] cnt_q;
  logic       is_half;
  logic       is_byte;
  logic       misaligned;

  // Codes 101..111 fall through to the word rule.
  always_comb begin
    is_half    = (req_dm_ctrl == 3'b001) || (req_dm_ctrl == 3'b010);
    is_byte    = (req_dm_ctrl == 3'b011) || (req_dm_ctrl == 3'b100);
    misaligned = 1'b0;
    if (is_half) begin
      misaligned = req_addr[0];
    end else if (!is_byte) begin
      misaligned = |req_addr[1:0];
    end
  end

  // Idle stall follows req_valid directly so the request is held until it is accepted.
  always_comb begin
    stall = 1'b0;
    if (state_q == StIdle) begin
      stall = req_valid;
    end else if ((state_q == StAcc) || (state_q == StWait)) begin
      stall = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= StIdle;
      we_q          <= 1'b0;
      cnt_q         <= 2'd0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= 32'd0;
      misalign_exc  <= 1'b0;
      misalign_addr <= 32'd0;
      bram_en       <= 1'b0;
      bram_wea      <= 4'd0;
      bram_addr     <= '0;
      bram_din      <= 32'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            if (misaligned) begin
              misalign_exc  <= 1'b1;
              misalign_addr <= req_addr;
              state_q       <= StExc;
            end else begin
              // The BRAM-facing registers double as the latched request.
              bram_en   <= 1'b1;
              bram_wea  <= req_we ? req_wea : 4'd0;
              bram_addr <= req_addr[DEPTH_LOG2+1:2];
              bram_din  <= req_wdata;
              we_q      <= req_we;
              state_q   <= StAcc;
            end
          end
        end
        StAcc: begin
          bram_en  <= 1'b0;
          bram_wea <= 4'd0;
          if (we_q) begin
            rsp_valid <= 1'b1;
            state_q   <= StResp;
          end else begin
            cnt_q   <= LatInit;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q == 2'd1) begin
            rsp_rdata <= bram_dout;
            rsp_valid <= 1'b1;
            state_q   <= StResp;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        StResp: begin
          rsp_valid <= 1'b0;
          state_q   <= StIdle;
        end
        StExc: begin
          misalign_exc <= 1'b0;
          state_q      <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_seq.sv
// Bench for dm_access_seq: two instances (read latency 1 and 3), each with an emulated BRAM,
// checked every cycle against a transaction-timeline model plus literal expectations.
module tb_dm_access_seq;

  logic        clk = 1'b0;
  logic        rstn;
  logic        chk_en = 1'b0;

  logic        req_valid [2];
  logic        req_we [2];
  logic [31:0] req_addr [2];
  logic [2:0]  req_dm_ctrl [2];
  logic [3:0]  req_wea [2];
  logic [31:0] req_wdata [2];
  logic        stall [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        misalign_exc [2];
  logic [31:0] misalign_addr [2];
  logic        bram_en [2];
  logic [3:0]  bram_wea [2];
  logic [9:0]  bram_addr [2];
  logic [31:0] bram_din [2];
  logic [31:0] bram_dout [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dm_access_seq #(.DEPTH_LOG2(10), .READ_LAT(1)) u_dut_l1 (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid[0]), .req_we(req_we[0]), .req_addr(req_addr[0]),
    .req_dm_ctrl(req_dm_ctrl[0]), .req_wea(req_wea[0]), .req_wdata(req_wdata[0]),
    .stall(stall[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .misalign_exc(misalign_exc[0]), .misalign_addr(misalign_addr[0]),
    .bram_en(bram_en[0]), .bram_wea(bram_wea[0]), .bram_addr(bram_addr[0]),
    .bram_din(bram_din[0]), .bram_dout(bram_dout[0])
  );

  dm_access_seq #(.DEPTH_LOG2(10), .READ_LAT(3)) u_dut_l3 (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid[1]), .req_we(req_we[1]), .req_addr(req_addr[1]),
    .req_dm_ctrl(req_dm_ctrl[1]), .req_wea(req_wea[1]), .req_wdata(req_wdata[1]),
    .stall(stall[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .misalign_exc(misalign_exc[1]), .misalign_addr(misalign_addr[1]),
    .bram_en(bram_en[1]), .bram_wea(bram_wea[1]), .bram_addr(bram_addr[1]),
    .bram_din(bram_din[1]), .bram_dout(bram_dout[1])
  );

  function automatic int lat(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // kind: 0 store, 1 load, 2 misaligned; returns the cycle (after accept) of the final phase
  function automatic int last_ph(int d, int k);
    if (k == 2) return 1;
    if (k == 0) return 2;
    return 2 + lat(d);
  endfunction

  function automatic bit misal(logic [2:0] c, logic [31:0] a);
    if (c == 3'd1 || c == 3'd2) return a[0];
    if (c == 3'd3 || c == 3'd4) return 1'b0;
    return a[1:0] != 2'b00;
  endfunction

  function automatic logic [31:0] seed(int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A_0000;
  endfunction

  // Emulated BRAM: read-before-write, output valid lat(d) cycles after the enabled edge.
  bit          mem_init = 1'b0;
  logic [31:0] bmem [2][1024];
  logic [31:0] bp [2][3];
  assign bram_dout[0] = bp[0][0];
  assign bram_dout[1] = bp[1][2];

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 1024; i++) bmem[d][i] <= seed(i);
      mem_init <= 1'b1;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (bram_en[d]) begin
          bp[d][0] <= bmem[d][bram_addr[d]];
          for (int b = 0; b < 4; b++)
            if (bram_wea[d][b]) bmem[d][bram_addr[d]][8*b +: 8] <= bram_din[d][8*b +: 8];
        end
        bp[d][1] <= bp[d][0];
        bp[d][2] <= bp[d][1];
      end
    end
  end

  // Reference model: one outstanding transaction, timeline counted in cycles since accept.
  bit          act [2];
  int          phase [2];
  int          kind [2];
  logic [31:0] t_addr [2];
  logic [31:0] t_wdata [2];
  logic [3:0]  t_wea [2];
  logic [31:0] e_rdata [2];
  logic [31:0] e_maddr [2];
  logic [31:0] rmem [2][1024];
  bit          rinit = 1'b0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      if (!rinit) begin
        for (int d = 0; d < 2; d++)
          for (int i = 0; i < 1024; i++) rmem[d][i] <= seed(i);
        rinit <= 1'b1;
      end
      for (int d = 0; d < 2; d++) begin
        act[d]     <= 1'b0;
        phase[d]   <= 0;
        kind[d]    <= 0;
        e_rdata[d] <= 32'd0;
        e_maddr[d] <= 32'd0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (act[d]) begin
          if (phase[d] >= last_ph(d, kind[d])) act[d] <= 1'b0;
          else phase[d] <= phase[d] + 1;
          if (kind[d] == 0 && phase[d] == 1)
            for (int b = 0; b < 4; b++)
              if (t_wea[d][b]) rmem[d][t_addr[d][11:2]][8*b +: 8] <= t_wdata[d][8*b +: 8];
          if (kind[d] == 1 && phase[d] + 1 == last_ph(d, 1))
            e_rdata[d] <= rmem[d][t_addr[d][11:2]];
        end else if (req_valid[d]) begin
          act[d]     <= 1'b1;
          phase[d]   <= 1;
          t_addr[d]  <= req_addr[d];
          t_wea[d]   <= req_wea[d];
          t_wdata[d] <= req_wdata[d];
          if (misal(req_dm_ctrl[d], req_addr[d])) begin
            kind[d]    <= 2;
            e_maddr[d] <= req_addr[d];
          end else begin
            kind[d] <= req_we[d] ? 0 : 1;
          end
        end
      end
    end
  end

  task automatic check(string name, int d, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%h exp=%h t=%0t", name, d, got, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int d = 0; d < 2; d++) begin
          int   lp;
          logic es, een, ersp, eexc;
          logic [3:0] ewea;
          lp   = last_ph(d, kind[d]);
          es   = act[d] ? (kind[d] != 2 && phase[d] < lp) : req_valid[d];
          een  = act[d] && kind[d] != 2 && phase[d] == 1;
          ewea = (een && kind[d] == 0) ? t_wea[d] : 4'd0;
          ersp = act[d] && kind[d] != 2 && phase[d] == lp;
          eexc = act[d] && kind[d] == 2;
          check("stall", d, stall[d], es);
          check("bram_en", d, bram_en[d], een);
          check("bram_wea", d, bram_wea[d], ewea);
          check("rsp_valid", d, rsp_valid[d], ersp);
          check("misalign_exc", d, misalign_exc[d], eexc);
          check("rsp_rdata", d, rsp_rdata[d], e_rdata[d]);
          check("misalign_addr", d, misalign_addr[d], e_maddr[d]);
          if (een) begin
            check("bram_addr", d, bram_addr[d], t_addr[d][11:2]);
            check("bram_din", d, bram_din[d], t_wdata[d]);
          end
        end
      end
    end
  endtask

  // Issues one request and observes it until rsp_valid/misalign_exc (bounded).
  task automatic do_req(input int d, input logic we, input logic [31:0] addr,
                        input logic [2:0] ctrl, input logic [3:0] wea, input logic [31:0] wdata,
                        output int cyc, output int st_cnt, output int en_cnt, output int rsp_cnt,
                        output logic [9:0] en_addr, output logic [3:0] en_wea);
    bit done;
    @(posedge clk);
    #1;
    req_we[d] = we; req_addr[d] = addr; req_dm_ctrl[d] = ctrl;
    req_wea[d] = wea; req_wdata[d] = wdata; req_valid[d] = 1'b1;
    cyc = 0; st_cnt = 0; en_cnt = 0; rsp_cnt = 0; en_addr = '0; en_wea = '0; done = 1'b0;
    @(negedge clk);
    if (stall[d]) st_cnt++;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (stall[d]) st_cnt++;
      if (bram_en[d]) begin
        en_cnt++; en_addr = bram_addr[d]; en_wea = bram_wea[d];
      end
      if (rsp_valid[d]) rsp_cnt++;
      if (rsp_valid[d] || misalign_exc[d]) begin
        done = 1'b1;
        req_valid[d] = 1'b0;
      end
    end
    req_valid[d] = 1'b0;
    check("done", d, done, 1'b1);
  endtask

  task automatic check_zero(int d, logic [31:0] maddr_exp);
    check("rst_stall", d, stall[d], 1'b0);
    check("rst_rsp_valid", d, rsp_valid[d], 1'b0);
    check("rst_rsp_rdata", d, rsp_rdata[d], 32'd0);
    check("rst_exc", d, misalign_exc[d], 1'b0);
    check("rst_maddr", d, misalign_addr[d], maddr_exp);
    check("rst_bram_en", d, bram_en[d], 1'b0);
    check("rst_bram_wea", d, bram_wea[d], 4'd0);
  endtask

  initial begin
    int cyc, st_cnt, en_cnt, rsp_cnt;
    logic [9:0] en_addr;
    logic [3:0] en_wea;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'd0;
      req_dm_ctrl[d] = 3'd0; req_wea[d] = 4'd0; req_wdata[d] = 32'd0;
    end
    rstn = 1'b1;
    fork
      compare_loop();
    join_none
    #3 rstn = 1'b0;
    #1 chk_en = 1'b1;
    check_zero(0, 32'd0);
    check_zero(1, 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Latency 1: directed store/load/byte-merge/misaligned
    do_req(0, 1'b1, 32'h10, 3'b000, 4'hF, 32'hDEADBEEF, cyc, st_cnt, en_cnt, rsp_cnt, en_addr, en_wea);
    check("st_lat", 0, cyc, 2);
    check("st_en_cnt", 0, en_cnt, 1);
    check("st_bram_addr", 0, en_addr, 10'd4);
    check("st_bram_wea", 0, en_wea, 4'hF);
    do_req(0, 1'b0, 32'h10, 3'b000, 4'h0, 32'h0, cyc, st_cnt, en_cnt, rsp_cnt, en_addr, en_wea);
    check("ld_lat", 0, cyc, 3);
    check("ld_stall_cycles", 0, st_cnt, 3);
    check("ld_bram_wea", 0, en_wea, 4'h0);
    check("ld_rdata", 0, rsp_rdata[0], 32'hDEADBEEF);
    do_req(0, 1'b1, 32'h13, 3'b011, 4'h8, 32'hABABABAB, cyc, st_cnt, en_cnt, rsp_cnt, en_addr, en_wea);
    check("sb_bram_wea", 0, en_wea, 4'h8);
    do_req(0, 1'b0, 32'h10, 3'b000, 4'h0, 32'h0, cyc, st_cnt, en_cnt, rsp_cnt, en_addr, en_wea);
    check("ld_merged", 0, rsp_rdata[0], 32'hABADBEEF);
    do_req(0, 1'b0, 32'h21, 3'b001, 4'h0, 32'h0, cyc, st_cnt, en_cnt, rsp_cnt, en_addr, en_wea);
    check("exc_cycle", 0, cyc, 1);
    check("exc_addr", 0, misalign_addr[0], 32'h21);
    check("exc_no_bram", 0, en_cnt, 0);
    check("exc_no_rsp", 0, rsp_cnt, 0);
    repeat (3) @(negedge clk);
    check("exc_one_cycle", 0, misalign_exc[0], 1'b0);

    // Latency 3 plus address aliasing
    do_req(1, 1'b1, 32'h10, 3'b000, 4'hF, 32'hDEADBEEF, cyc, st_cnt, en_cnt, rsp_cnt, en_addr, en_wea);
    check("l3_st_lat", 1, cyc, 2);
    do_req(1, 1'b0, 32'h1000_0010, 3'b000, 4'h0, 32'h0, cyc, st_cnt, en_cnt, rsp_cnt, en_addr, en_wea);
    check("l3_ld_lat", 1, cyc, 5);
    check("l3_alias_addr", 1, en_addr, 10'd4);
    check("l3_ld_rdata", 1, rsp_rdata[1], 32'hDEADBEEF);

    // Reset in the middle of a latency-3 load
    @(posedge clk); #1;
    req_we[1] = 1'b0; req_addr[1] = 32'h10; req_dm_ctrl[1] = 3'b000; req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_wait_stall", 1, stall[1], 1'b1);
    rstn = 1'b0;
    #1;
    check_zero(1, 32'd0);
    check_zero(0, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    rsp_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid[1]) rsp_cnt++;
    end
    check("no_rsp_after_rst", 1, rsp_cnt, 0);

    // Randomized traffic on both latencies
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 80; n++) begin
        logic [31:0] a;
        a = $urandom & 32'hF000_003F;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        do_req(d, 1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)), 4'($urandom),
               $urandom, cyc, st_cnt, en_cnt, rsp_cnt, en_addr, en_wea);
      end
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
